frame_streamer: RTL and testbench
=================================

# frame_streamer

Double-buffered frame source that emits an image as a raster-order pixel stream (`frame_start`, `pixel_out`, `pixel_valid`) for the sliding-window generator in the convolution front end. A host or DMA fills one bank through a simple write port while the other bank is streamed. Inter-frame spacing is enforced so the downstream window block finishes its current frame before the next `frame_start`.

## Interface
- `DATA_WIDTH`, 16, pixel width
- `IMG_WIDTH`, 32, pixels per row
- `IMG_HEIGHT`, 32, rows per frame
- `FRAME_GAP`, 72, minimum idle cycles after the last pixel before the next `frame_start`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `wr_en`  in  1  write strobe for the fill bank
- `wr_addr`  in  ADDR_W  pixel index, raster order (y*IMG_WIDTH+x)
- `wr_data`  in  DATA_WIDTH  pixel value
- `wr_done`  in  1  pulse: the fill bank is complete; mark it full
- `wr_ready`  out  1  fill bank is free; writes are accepted
- `tx_enable`  in  1  permits starting a new frame
- `hold`  in  1  pause the stream (back-pressure)
- `frame_start`  out  1  one-cycle pulse preceding pixel 0
- `pixel_out`  out  DATA_WIDTH  streamed pixel
- `pixel_valid`  out  1  `pixel_out` is valid
- `frame_done`  out  1  one-cycle pulse after the last pixel
- `busy`  out  1  state is not IDLE

## Operation
- Two banks, each IMG_WIDTH*IMG_HEIGHT words. `ADDR_W = $clog2(IMG_WIDTH*IMG_HEIGHT)`.
- Bank pointers and flags:
  - `wr_bank` and `rd_bank` are 1-bit pointers; `bank_full[1:0]` holds per-bank flags.
  - `wr_ready = !bank_full[wr_bank]`.
- Write side:
  - `wr_en` with `wr_ready` low is ignored. `wr_addr` at or above W*H is ignored.
  - `wr_done` with `wr_ready` high sets `bank_full[wr_bank]` and toggles `wr_bank`. `wr_done` with `wr_ready` low is ignored.
- FSM states: IDLE, START, STREAM, GAP.
- IDLE → START when `tx_enable && bank_full[rd_bank]`.
- START lasts one cycle:
  - `frame_start` = 1.
  - Read address 0 is issued, regardless of `hold`.
  - Next state is STREAM.
- STREAM:
  - Each cycle with `hold` low issues the next read address.
  - The address after W*H-1 is not issued; once the last read completes, the FSM enters GAP.
- Entering GAP:
  - `bank_full[rd_bank]` is cleared, `rd_bank` toggles, and `frame_done` pulses.
  - The FSM counts FRAME_GAP cycles, then returns to IDLE.
- A clear of `rd_bank` and a set of `wr_bank` in the same cycle on different banks both take effect. They cannot target the same bank.
- Reset mid-frame: the stream aborts immediately and all flags and pointers clear. The partially streamed frame is lost, and no `frame_done` is produced.

## Timing
- Reset values:
  - `frame_start`, `pixel_valid`, `frame_done`, `busy` = 0.
  - `pixel_out` = 0.
  - `wr_ready` = 1.
  - Both bank pointers = 0; `bank_full` = 00; FSM in IDLE.
- Memory read is synchronous with 1-cycle latency. `pixel_valid`/`pixel_out` assert the cycle after the read is issued.
- `frame_start` at cycle t; pixel 0 valid at t+1 at the earliest. `frame_start` and `pixel_valid` are never high in the same cycle.
- With `hold` low throughout, pixels are valid at t+1 … t+W*H with no bubbles.
- `hold` high in cycle c: no read issued in c, so `pixel_valid` is low in c+1. The stream resumes one cycle after `hold` drops.
- `frame_done` is high in the cycle after the last valid pixel.
- Earliest next `frame_start` is FRAME_GAP+1 cycles after `frame_done`.
- `wr_ready` updates the cycle after `wr_done` or after a bank clear.

## Structure
- Package `cnn_stream_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_START`, `ST_STREAM`, `ST_GAP`).
  - `ADDR_W` derivation function and gap-counter width helper.
- Sub-module `frame_bank_ram`: two banks, one write port, one synchronous read port, bank select per port. The top level holds the FSM, pointers, flags, read-address counter and gap counter.

## Test plan
- Fill bank 0 with value = index (0…1023), `wr_done`, `tx_enable`=1:
  - `frame_start` one cycle, then 1024 consecutive `pixel_valid` cycles with `pixel_out` 0…1023.
  - `frame_done` one cycle later; `wr_ready` stays 1 while bank 1 fills.
- Fill both banks, second frame = index+4096:
  - Two frames stream back to back, second `frame_start` exactly FRAME_GAP+1 cycles after first `frame_done`.
  - `wr_ready` = 0 while both are full, returning to 1 after the first `frame_done`.
- Pulse `hold` for 3 cycles at pixel 100:
  - Exactly 3 `pixel_valid` bubbles, no pixel skipped or duplicated, total valid count 1024.
- `wr_done` while both banks are full, plus writes with `wr_ready` = 0:
  - Ignored; streamed data is unchanged and `bank_full` is unchanged.
- Assert `rst` at pixel 500:
  - All outputs 0 and `wr_ready` = 1 next cycle, no `frame_done`.
  - After refill, the stream restarts from bank 0, pixel 0.
- `tx_enable` = 0 with a full bank: stays IDLE and `busy` = 0. On raising `tx_enable`, `frame_start` follows 1 cycle later.

Source files
------------

// File: rtl/cnn_stream_pkg.sv
// Shared types and sizing helpers for the convolution front-end stream blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cnn_stream_pkg;

  // Frame streamer FSM encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_START  = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_GAP    = 2'd3;

  // Pixel index width for a w x h frame, never narrower than one bit.
  function automatic int calc_addr_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

  // The gap counter runs 0 .. gap-1, so it needs clog2(gap) bits.
  function automatic int gap_cnt_w(input int gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank pixel store: one write port and one read port, each with its own bank select.
// Latency: read data registered, valid one cycle after rd_en.
// Backpressure: none; rd_data holds its last value while rd_en is low.
module frame_bank_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_bank,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  rd_bank,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];

  // Array writes carry no reset so each bank maps onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_bank) mem0[wr_addr] <= wr_data;
    if (wr_en && wr_bank)  mem1[wr_addr] <= wr_data;
  end

  // Synchronous read; the output register clears on reset so the stream output starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
    end
  end

endmodule

// File: rtl/frame_streamer.sv
// Double-buffered frame source: host fills one bank while the other streams in raster order.
// Latency: frame_start at t, pixels t+1..t+W*H, frame_done one cycle after the last pixel.
// Backpressure: hold stalls read issue (one bubble per held cycle); wr_ready low drops writes.
module frame_streamer
  import cnn_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int IMG_WIDTH  = 32,
  parameter  int IMG_HEIGHT = 32,
  parameter  int FRAME_GAP  = 72,
  localparam int ADDR_W     = calc_addr_w(IMG_WIDTH, IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_done,
  output logic                  wr_ready,
  input  logic                  tx_enable,
  input  logic                  hold,
  output logic                  frame_start,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_valid,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  // One extra bit so the counter can hold NPIX, meaning "every address issued".
  localparam int CNT_W = ADDR_W + 1;
  localparam int GAP_W = gap_cnt_w(FRAME_GAP);

  localparam logic [CNT_W-1:0] NPIX_CNT = CNT_W'(NPIX);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

  state_t             state;
  state_t             state_nxt;
  logic               wr_bank;
  logic               rd_bank;
  logic [1:0]         bank_full;
  logic [CNT_W-1:0]   rd_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               wr_accept;
  logic               done_accept;
  logic               frame_end;

  assign wr_ready    = !bank_full[wr_bank];
  assign wr_accept   = wr_en && wr_ready && ({1'b0, wr_addr} < NPIX_CNT);
  assign done_accept = wr_done && wr_ready;
  // All reads issued and the last pixel is on the output this cycle.
  assign frame_end   = (state == ST_STREAM) && (rd_cnt == NPIX_CNT);

  assign frame_start = (state == ST_START);
  assign busy        = (state != ST_IDLE);

  // Next-state and read-issue decode; START always issues address 0 even under hold.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state)
      ST_IDLE: begin
        if (tx_enable && bank_full[rd_bank]) state_nxt = ST_START;
      end
      ST_START: begin
        rd_en     = 1'b1;
        state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (rd_cnt == NPIX_CNT) begin
          state_nxt = ST_GAP;
        end else if (!hold) begin
          rd_en   = 1'b1;
          rd_addr = rd_cnt[ADDR_W-1:0];
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, read-address counter and inter-frame gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rd_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_START) begin
        rd_cnt <= CNT_W'(1);
      end else if (rd_en) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      if (frame_end) begin
        gap_cnt <= '0;
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

  // Bank ownership: the fill side sets its flag, the stream side clears its own; they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      if (done_accept) begin
        bank_full[wr_bank] <= 1'b1;
        wr_bank            <= ~wr_bank;
      end
      if (frame_end) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end
    end
  end

  // Output strobes: valid follows read issue by one cycle, done marks entry into the gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      pixel_valid <= rd_en;
      frame_done  <= frame_end;
    end
  end

  frame_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NPIX),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_data (pixel_out)
  );

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: fills push expected pixels, the stream pops and compares.
// Latency: checks frame_start -> first pixel, last pixel -> frame_done, and the inter-frame gap.
// Backpressure: exercises hold bubbles and writes/wr_done with wr_ready low.
module tb_frame_streamer;

  localparam int DW   = 16;
  localparam int IW   = 32;
  localparam int IH   = 32;
  localparam int GAP  = 72;
  localparam int AW   = 10;
  localparam int NPIX = IW * IH;

  typedef struct {
    int t_start;
    int t_done;
    int n_valid;
    int first_v;
    int last_v;
    int n_done;
    int bad;
    int overlap;
    int rdy_hi;
    int rdy_at_done;
  } fstat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_done;
  logic          wr_ready;
  logic          tx_enable;
  logic          hold;
  logic          frame_start;
  logic [DW-1:0] pixel_out;
  logic          pixel_valid;
  logic          frame_done;
  logic          busy;

  logic [DW-1:0] exp_q [$];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  frame_streamer #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH),
    .FRAME_GAP  (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_done     (wr_done),
    .wr_ready    (wr_ready),
    .tx_enable   (tx_enable),
    .hold        (hold),
    .frame_start (frame_start),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Write one full bank (value = base + index) and queue the expected stream.
  task automatic fill_bank(input int base);
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = DW'(base + i);
      exp_q.push_back(DW'(base + i));
    end
    @(negedge clk);
    wr_en   = 1'b0;
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
  endtask

  // Follow one frame, popping the scoreboard per valid pixel; optional hold pulse.
  task automatic watch_frame(input bit started, input int hold_at, input int hold_len,
                             output fstat_t s);
    int k;
    int hold_left;
    bit held;
    logic [DW-1:0] e;
    s.t_start = -1; s.t_done = -1; s.n_valid = 0; s.first_v = -1; s.last_v = -1;
    s.n_done = 0; s.bad = 0; s.overlap = 0; s.rdy_hi = 0; s.rdy_at_done = -1;
    hold_left = 0;
    held = 1'b0;
    if (started) begin
      s.t_start = cyc;
      if (pixel_valid === 1'b1) s.overlap++;
    end else begin
      k = 0;
      while (k < 200) begin
        @(negedge clk);
        k++;
        if (frame_start === 1'b1) begin
          s.t_start = cyc;
          if (pixel_valid === 1'b1) s.overlap++;
          break;
        end
      end
      if (s.t_start < 0) return;
    end
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      k++;
      if (frame_done === 1'b1) begin
        s.n_done++;
        s.t_done = cyc;
        s.rdy_at_done = (wr_ready === 1'b1) ? 1 : 0;
        break;
      end
      if (wr_ready === 1'b1) s.rdy_hi++;
      if (pixel_valid === 1'b1) begin
        if (frame_start === 1'b1) s.overlap++;
        if (s.first_v < 0) s.first_v = cyc;
        s.last_v = cyc;
        s.n_valid++;
        if (exp_q.size() == 0) begin
          s.bad++;
        end else begin
          e = exp_q.pop_front();
          if (pixel_out !== e) s.bad++;
        end
      end
      if (!held && s.n_valid == hold_at) begin
        hold      = 1'b1;
        hold_left = hold_len;
        held      = 1'b1;
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) hold = 1'b0;
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_done = 1'b0;
    tx_enable = 1'b0; hold = 1'b0;
    @(negedge clk);
    n_chk++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start: got %b want 0", frame_start); else n_pass++;
    n_chk++; if (pixel_valid !== 1'b0) $display("FAIL rst_pixel_valid: got %b want 0", pixel_valid); else n_pass++;
    n_chk++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b want 0", frame_done); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (pixel_out !== '0) $display("FAIL rst_pixel_out: got %h want 0", pixel_out); else n_pass++;
    n_chk++; if (wr_ready !== 1'b1) $display("FAIL rst_wr_ready: got %b want 1", wr_ready); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_tx_gate();
    int busy_seen;
    fill_bank(0);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b1 || frame_start === 1'b1) busy_seen++;
    end
    n_chk++; if (busy_seen !== 0) $display("FAIL gate_idle: busy/start cycles %0d want 0", busy_seen); else n_pass++;
    n_chk++; if (wr_ready !== 1'b1) $display("FAIL gate_wr_ready: got %b want 1", wr_ready); else n_pass++;
    tx_enable = 1'b1;
    @(negedge clk);
    n_chk++; if (frame_start !== 1'b1) $display("FAIL gate_start: got %b want 1", frame_start); else n_pass++;
  endtask

  task automatic test_single_frame();
    fstat_t s;
    watch_frame(1'b1, -1, 0, s);
    n_chk++; if (s.n_valid !== NPIX) $display("FAIL single_count: got %0d want %0d", s.n_valid, NPIX); else n_pass++;
    n_chk++; if (s.bad !== 0) $display("FAIL single_data: bad pixels %0d want 0", s.bad); else n_pass++;
    n_chk++; if (s.first_v !== s.t_start + 1) $display("FAIL single_first: got %0d want %0d", s.first_v, s.t_start + 1); else n_pass++;
    n_chk++; if (s.last_v !== s.t_start + NPIX) $display("FAIL single_last: got %0d want %0d", s.last_v, s.t_start + NPIX); else n_pass++;
    n_chk++; if (s.t_done !== s.last_v + 1) $display("FAIL single_done: got %0d want %0d", s.t_done, s.last_v + 1); else n_pass++;
    n_chk++; if (s.overlap !== 0) $display("FAIL single_overlap: got %0d want 0", s.overlap); else n_pass++;
    n_chk++; if (s.rdy_hi !== s.t_done - s.t_start - 1) $display("FAIL single_wr_ready: high %0d want %0d", s.rdy_hi, s.t_done - s.t_start - 1); else n_pass++;
  endtask

  task automatic test_ignored_writes();
    tx_enable = 1'b0;
    fill_bank(0);
    fill_bank(4096);
    n_chk++; if (wr_ready !== 1'b0) $display("FAIL full_wr_ready: got %b want 0", wr_ready); else n_pass++;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 16'hDEAD;
    @(negedge clk);
    wr_en = 1'b0; wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    @(negedge clk);
    n_chk++; if (wr_ready !== 1'b0) $display("FAIL ignored_wr_ready: got %b want 0", wr_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    fstat_t s1;
    fstat_t s2;
    int extra;
    tx_enable = 1'b1;
    watch_frame(1'b0, -1, 0, s1);
    watch_frame(1'b0, -1, 0, s2);
    n_chk++; if (s1.bad !== 0 || s1.n_valid !== NPIX) $display("FAIL b2b_frame1: bad %0d count %0d want 0/%0d", s1.bad, s1.n_valid, NPIX); else n_pass++;
    n_chk++; if (s2.bad !== 0 || s2.n_valid !== NPIX) $display("FAIL b2b_frame2: bad %0d count %0d want 0/%0d", s2.bad, s2.n_valid, NPIX); else n_pass++;
    n_chk++; if (s1.rdy_hi !== 0) $display("FAIL b2b_wr_ready_low: high cycles %0d want 0", s1.rdy_hi); else n_pass++;
    n_chk++; if (s1.rdy_at_done !== 1) $display("FAIL b2b_wr_ready_done: got %0d want 1", s1.rdy_at_done); else n_pass++;
    n_chk++; if (s2.t_start - s1.t_done !== GAP + 1) $display("FAIL b2b_gap: got %0d want %0d", s2.t_start - s1.t_done, GAP + 1); else n_pass++;
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) extra++;
    end
    n_chk++; if (extra !== 0) $display("FAIL b2b_no_third: starts %0d want 0", extra); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL b2b_idle: busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_hold();
    fstat_t s;
    int bubbles;
    fill_bank(16'h3000);
    watch_frame(1'b0, 100, 3, s);
    bubbles = s.last_v - s.first_v + 1 - s.n_valid;
    n_chk++; if (s.n_valid !== NPIX) $display("FAIL hold_count: got %0d want %0d", s.n_valid, NPIX); else n_pass++;
    n_chk++; if (bubbles !== 3) $display("FAIL hold_bubbles: got %0d want 3", bubbles); else n_pass++;
    n_chk++; if (s.bad !== 0) $display("FAIL hold_data: bad pixels %0d want 0", s.bad); else n_pass++;
    n_chk++; if (s.t_done !== s.last_v + 1) $display("FAIL hold_done: got %0d want %0d", s.t_done, s.last_v + 1); else n_pass++;
  endtask

  task automatic test_reset_abort();
    fstat_t s;
    int nv;
    int k;
    int nd;
    int ns;
    tx_enable = 1'b0;
    fill_bank(0);
    tx_enable = 1'b1;
    nv = 0;
    k = 0;
    while (nv < 500 && k < 1000) begin
      @(negedge clk);
      k++;
      if (pixel_valid === 1'b1) nv++;
    end
    n_chk++; if (nv !== 500) $display("FAIL abort_reach: pixels %0d want 500", nv); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({frame_start, pixel_valid, frame_done, busy} !== 4'b0000) $display("FAIL abort_strobes: got %b want 0000", {frame_start, pixel_valid, frame_done, busy}); else n_pass++;
    n_chk++; if (pixel_out !== '0) $display("FAIL abort_pixel_out: got %h want 0", pixel_out); else n_pass++;
    n_chk++; if (wr_ready !== 1'b1) $display("FAIL abort_wr_ready: got %b want 1", wr_ready); else n_pass++;
    rst = 1'b0;
    exp_q.delete();
    nd = 0;
    ns = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) nd++;
      if (frame_start === 1'b1) ns++;
    end
    n_chk++; if (nd !== 0 || ns !== 0) $display("FAIL abort_quiet: done %0d start %0d want 0/0", nd, ns); else n_pass++;
    fill_bank(16'h2000);
    watch_frame(1'b0, -1, 0, s);
    n_chk++; if (s.t_start < 0) $display("FAIL refill_start: no frame_start seen, want one"); else n_pass++;
    n_chk++; if (s.bad !== 0 || s.n_valid !== NPIX) $display("FAIL refill_data: bad %0d count %0d want 0/%0d", s.bad, s.n_valid, NPIX); else n_pass++;
    n_chk++; if (s.first_v !== s.t_start + 1) $display("FAIL refill_first: got %0d want %0d", s.first_v, s.t_start + 1); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx_gate();
    test_single_frame();
    test_ignored_writes();
    test_back_to_back();
    test_hold();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
